// File: rtl/psum_out_buffer.sv
// Partial-sum output FIFO between the convolution controller and the memory writer.
// Entries carry the controller's filter/row end tags; the head is presented first-word-fall-through.
module psum_out_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              store_buffer,
  input  logic [DATA_W-1:0] sum_in,
  input  logic              next_filter,
  input  logic              next_row,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_filt_last,
  output logic              out_row_last,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              almost_full,
  output logic              overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = DATA_W + 2;

  localparam logic [CNT_W-1:0] CNT_DEPTH    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ALMOST   = CNT_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic [ENTRY_W-1:0] mem_reg [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;

  logic               empty;
  logic               push;
  logic               pop;
  logic               drop;
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] head_entry;

  // Status is derived only from registered count, so no input reaches these outputs combinationally.
  assign empty       = (count_reg == '0);
  assign full        = (count_reg == CNT_DEPTH);
  assign almost_full = (count_reg >= CNT_ALMOST);
  assign count       = count_reg;
  assign overflow    = overflow_reg;
  assign out_valid   = !empty;

  assign pop      = out_valid && out_ready;
  assign push     = store_buffer && (!full || pop);
  assign drop     = store_buffer && full && !pop;
  assign entry_in = {next_filter, next_row, sum_in};

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end

    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase

    if (drop) begin
      overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage needs no reset: the head outputs are masked while the FIFO is empty.
  // A push never targets the occupied head slot, so a stalled head stays put.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst && push && (wr_ptr_reg == PTR_W'(gi))) begin
        mem_reg[gi] <= entry_in;
      end
    end
  end

  assign head_entry = mem_reg[rd_ptr_reg];

  always_comb begin
    out_data      = '0;
    out_filt_last = 1'b0;
    out_row_last  = 1'b0;
    if (!empty) begin
      out_filt_last = head_entry[ENTRY_W-1];
      out_row_last  = head_entry[ENTRY_W-2];
      out_data      = head_entry[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_psum_out_buffer.sv
// Directed self-checking bench for psum_out_buffer (DATA_W=16, DEPTH=8).
module tb_psum_out_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              store_buffer;
  logic [DATA_W-1:0] sum_in;
  logic              next_filter;
  logic              next_row;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_filt_last;
  logic              out_row_last;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              almost_full;
  logic              overflow;

  int checks;
  int passes;

  psum_out_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .store_buffer (store_buffer),
    .sum_in       (sum_in),
    .next_filter  (next_filter),
    .next_row     (next_row),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_filt_last(out_filt_last),
    .out_row_last (out_row_last),
    .count        (count),
    .full         (full),
    .almost_full  (almost_full),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    store_buffer = 1'b0;
    sum_in       = '0;
    next_filter  = 1'b0;
    next_row     = 1'b0;
    out_ready    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || full !== 1'b0 || almost_full !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL reset_status: count=%0d valid=%b full=%b af=%b ovf=%b, required 0/0/0/0/0",
               count, out_valid, full, almost_full, overflow);
    end else passes++;
    checks++;
    if (out_data !== 16'h0 || out_filt_last !== 1'b0 || out_row_last !== 1'b0) begin
      $display("FAIL reset_head: data=%h filt=%b row=%b, required 0000/0/0", out_data, out_filt_last, out_row_last);
    end else passes++;

    store_buffer = 1'b1; sum_in = 16'h1234; next_filter = 1'b1; next_row = 1'b0;
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_filt_last !== 1'b1 || out_row_last !== 1'b0 || count !== 4'd1) begin
      $display("FAIL single_entry: valid=%b data=%h filt=%b row=%b count=%0d, required 1/1234/1/0/1",
               out_valid, out_data, out_filt_last, out_row_last, count);
    end else passes++;
    $display("test_reset done");
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      store_buffer = 1'b1; sum_in = 16'(i); out_ready = 1'b0;
      tick();
      if (i < 8) begin
        checks++;
        if (count !== 4'(i + 1) || almost_full !== (i + 1 >= 7) || full !== (i + 1 == 8) || overflow !== 1'b0) begin
          $display("FAIL fill_%0d: count=%0d af=%b full=%b ovf=%b, required %0d/%b/%b/0",
                   i, count, almost_full, full, overflow, i + 1, (i + 1 >= 7), (i + 1 == 8));
        end else passes++;
      end
    end
    idle_inputs();
    checks++;
    if (count !== 4'd8 || overflow !== 1'b1 || full !== 1'b1) begin
      $display("FAIL overflow: count=%0d ovf=%b full=%b, required 8/1/1", count, overflow, full);
    end else passes++;

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(i)) begin
        $display("FAIL drain_%0d: valid=%b data=%0d, required 1/%0d", i, out_valid, out_data, i);
      end else passes++;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0 || out_data !== 16'h0 || overflow !== 1'b1) begin
      $display("FAIL drain_end: valid=%b count=%0d data=%h ovf=%b, required 0/0/0000/1",
               out_valid, count, out_data, overflow);
    end else passes++;
    $display("test_fill_overflow done");
  endtask

  task automatic test_full_push_pop();
    logic [DATA_W-1:0] exp_seq [8];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      store_buffer = 1'b1; sum_in = 16'(16'h10 + i);
      tick();
    end
    store_buffer = 1'b1; sum_in = 16'h00AA; out_ready = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0 || full !== 1'b1) begin
      $display("FAIL full_push_pop: count=%0d ovf=%b full=%b, required 8/0/1", count, overflow, full);
    end else passes++;

    for (int i = 0; i < 7; i++) exp_seq[i] = 16'(16'h11 + i);
    exp_seq[7] = 16'h00AA;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin
        $display("FAIL fpp_drain_%0d: valid=%b data=%h, required 1/%h", i, out_valid, out_data, exp_seq[i]);
      end else passes++;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      $display("FAIL fpp_empty: valid=%b count=%0d, required 0/0", out_valid, count);
    end else passes++;
    $display("test_full_push_pop done");
  endtask

  task automatic test_back_to_back();
    logic exp_f;
    logic exp_r;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_f = (i % 3 == 0);
      exp_r = (i % 2 == 1);
      store_buffer = 1'b1; sum_in = 16'(100 + i); next_filter = exp_f; next_row = exp_r;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(100 + i) || out_filt_last !== exp_f ||
          out_row_last !== exp_r || count !== 4'd1) begin
        $display("FAIL stream_%0d: valid=%b data=%0d filt=%b row=%b count=%0d, required 1/%0d/%b/%b/1",
                 i, out_valid, out_data, out_filt_last, out_row_last, count, 100 + i, exp_f, exp_r);
      end else passes++;
    end
    store_buffer = 1'b0;
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b0) begin
      $display("FAIL stream_end: valid=%b count=%0d ovf=%b, required 0/0/0", out_valid, count, overflow);
    end else passes++;
    $display("test_back_to_back done");
  endtask

  task automatic test_backpressure();
    do_reset();
    store_buffer = 1'b1; sum_in = 16'd5; next_row = 1'b1;
    tick();
    next_row = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data !== 16'd5 || out_valid !== 1'b1 || out_row_last !== 1'b1 || count !== 4'(i + 1)) begin
        $display("FAIL stall_%0d: data=%0d valid=%b row=%b count=%0d, required 5/1/1/%0d",
                 i, out_data, out_valid, out_row_last, count, i + 1);
      end else passes++;
      store_buffer = (i < 3); sum_in = 16'(6 + i); out_ready = 1'b0;
      tick();
    end
    idle_inputs();
    checks++;
    if (out_data !== 16'd5 || count !== 4'd4) begin
      $display("FAIL stall_end: data=%0d count=%0d, required 5/4", out_data, count);
    end else passes++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(5 + i)) begin
        $display("FAIL stall_drain_%0d: valid=%b data=%0d, required 1/%0d", i, out_valid, out_data, 5 + i);
      end else passes++;
      tick();
    end
    idle_inputs();
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      store_buffer = 1'b1; sum_in = 16'(16'h40 + i);
      tick();
    end
    store_buffer = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd5 || overflow !== 1'b1 || out_data !== 16'h43) begin
      $display("FAIL mid_pre: count=%0d ovf=%b data=%h, required 5/1/0043", count, overflow, out_data);
    end else passes++;

    // Push and pop requests during reset must be ignored.
    store_buffer = 1'b1; sum_in = 16'h7777; out_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== 16'h0 || almost_full !== 1'b0) begin
      $display("FAIL mid_reset: count=%0d valid=%b ovf=%b data=%h af=%b, required 0/0/0/0000/0",
               count, out_valid, overflow, out_data, almost_full);
    end else passes++;

    store_buffer = 1'b1; sum_in = 16'hBEEF; next_filter = 1'b1; next_row = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_filt_last !== 1'b1 || out_row_last !== 1'b1 || count !== 4'd1) begin
      $display("FAIL mid_after: valid=%b data=%h filt=%b row=%b count=%0d, required 1/beef/1/1/1",
               out_valid, out_data, out_filt_last, out_row_last, count);
    end else passes++;
    $display("test_reset_mid done");
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fill_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
